// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA screen constants and the blitter draw-state type
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int SCR_TITLE = 0;
  localparam int SCR_WIN = 1;
  localparam int SCR_LOSE = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} blit_state_e;
endpackage

// File: rtl/rom_blitter_blit_scan.sv
// blit_scan: draw FSM with row/column/address scan counters
module blit_scan
  import vga_pkg::*;
#(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int ROM_LAT = 1,
  parameter int CW = 8,
  parameter int RW = 7,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go,
  input  logic              frame,
  output logic              start,
  output logic              issue,
  output logic              last,
  output logic              busy,
  output logic [CW-1:0]     col,
  output logic [RW-1:0]     row,
  output logic [ADDR_W-1:0] addr
);
  blit_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0] drain_q, drain_d;
  logic col_end;
  always_comb begin
    start = state_q == ST_IDLE && go && frame;
    issue = state_q == ST_RUN;
    col_end = col_q == CW'(IMG_W - 1);
    last = issue && col_end && row_q == RW'(IMG_H - 1);
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    addr_d = addr_q;
    drain_d = drain_q;
    if (start) begin
      state_d = ST_RUN;
      col_d = '0;
      row_d = '0;
      addr_d = '0;
    end else if (last) begin
      state_d = ST_DRAIN;
      drain_d = 2'(ROM_LAT);
    end else if (issue) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      row_d = col_end ? row_q + 1'b1 : row_q;
      addr_d = addr_q + 1'b1;
    end else if (state_q == ST_DRAIN) begin
      // the last pixel needs ROM_LAT+1 cycles to reach the output registers
      state_d = drain_q == '0 ? ST_IDLE : ST_DRAIN;
      drain_d = drain_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      col_q <= '0;
      row_q <= '0;
      addr_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      addr_q <= addr_d;
      drain_q <= drain_d;
    end
  end
  assign busy = state_q != ST_IDLE;
  assign col = col_q;
  assign row = row_q;
  assign addr = addr_q;
endmodule

// File: rtl/rom_blitter.sv
// rom_blitter: copies a ROM-stored screen image to the VGA plot interface
module rom_blitter #(
  parameter int IMG_W = vga_pkg::SCREEN_W,
  parameter int IMG_H = vga_pkg::SCREEN_H,
  parameter int COLOUR_W = vga_pkg::COLOUR_W,
  parameter int N_SCREENS = 3,
  parameter int SEL_W = 2,
  parameter int XY_W = 10,
  parameter int ROM_LAT = 1,
  parameter int TRANSP_EN = 0,
  parameter int TRANSP_KEY = 0
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               go,
  input  logic                               frame,
  input  logic [SEL_W-1:0]                   screen_select,
  input  logic [XY_W-1:0]                    x0,
  input  logic [XY_W-1:0]                    y0,
  output logic [$clog2(IMG_W*IMG_H)-1:0]     rom_addr,
  input  logic [N_SCREENS*COLOUR_W-1:0]      rom_q_bus,
  output logic                               plot,
  output logic [XY_W-1:0]                    x,
  output logic [XY_W-1:0]                    y,
  output logic [COLOUR_W-1:0]                colour,
  output logic                               busy,
  output logic                               done
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(NPIX);
  localparam int L = ROM_LAT + 1;
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int SW = 2 + CW + RW;
  logic start, issue, last, t_vld, t_last;
  logic [CW-1:0] s_col, t_col;
  logic [RW-1:0] s_row, t_row;
  logic [(L-1)*SW-1:0] pipe_q, pipe_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [XY_W-1:0] x0_q, x0_d, y0_q, y0_d, x_q, x_d, y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d, pix;
  logic [COLOUR_W-1:0] img [N_SCREENS];
  logic plot_q, plot_d, done_q, done_d;
  blit_scan #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ROM_LAT(ROM_LAT), .CW(CW), .RW(RW), .ADDR_W(ADDR_W)
  ) u_scan (
    .clk(clk), .resetn(resetn), .go(go), .frame(frame), .start(start), .issue(issue),
    .last(last), .busy(busy), .col(s_col), .row(s_row), .addr(rom_addr)
  );
  for (genvar k = 0; k < N_SCREENS; k++) begin : g_img
    assign img[k] = rom_q_bus[k*COLOUR_W +: COLOUR_W];
  end
  // oldest stage sits at the top of pipe_q and lines up with rom_q_bus
  assign {t_vld, t_last, t_col, t_row} = pipe_q[(L-1)*SW-1 -: SW];
  always_comb begin
    pipe_d = ((L - 1) * SW)'({pipe_q, issue, last, s_col, s_row});
    sel_d = start ? screen_select : sel_q;
    x0_d = start ? x0 : x0_q;
    y0_d = start ? y0 : y0_q;
    pix = {1'b0, sel_q} < (SEL_W + 1)'(N_SCREENS) ? img[sel_q] : '0;
    colour_d = t_vld ? pix : colour_q;
    x_d = t_vld ? x0_q + XY_W'(t_col) : x_q;
    y_d = t_vld ? y0_q + XY_W'(t_row) : y_q;
    plot_d = t_vld && (TRANSP_EN == 0 || pix != COLOUR_W'(TRANSP_KEY));
    done_d = t_last;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pipe_q <= '0;
      sel_q <= '0;
      x0_q <= '0;
      y0_q <= '0;
      colour_q <= '0;
      x_q <= '0;
      y_q <= '0;
      plot_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pipe_q <= pipe_d;
      sel_q <= sel_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      colour_q <= colour_d;
      x_q <= x_d;
      y_q <= y_d;
      plot_q <= plot_d;
      done_q <= done_d;
    end
  end
  assign plot = plot_q;
  assign x = x_q;
  assign y = y_q;
  assign colour = colour_q;
  assign done = done_q;
endmodule

// File: tb/tb_rom_blitter.sv
// tb_rom_blitter: three blitter configurations checked against a pixel-index model of a draw
module tb_rom_blitter;
  localparam int NW [3] = '{160, 4, 4};
  localparam int NH [3] = '{120, 2, 2};
  localparam int NL [3] = '{1, 3, 2};
  localparam int NT [3] = '{0, 0, 1};
  typedef struct {
    int d; int sel; int x0; int y0; int plots; int first_off; int fx; int fy;
    int done_off; int lx; int ly; int lplot;
  } draw_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn [3];
  logic go [3];
  logic frame [3];
  logic [1:0] sel [3];
  logic [9:0] x0 [3];
  logic [9:0] y0 [3];
  logic [14:0] addr [3];
  logic [8:0] bus [3];
  logic plot [3];
  logic busy [3];
  logic done [3];
  logic [9:0] xo [3];
  logic [9:0] yo [3];
  logic [2:0] col [3];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc [3];
  int msel [3];
  int mx0 [3];
  int my0 [3];
  bit rst_pend [3];
  logic [9:0] ex [3];
  logic [9:0] ey [3];
  logic [2:0] ec [3];
  int ea [3];

  function automatic logic [2:0] romv(int g, int k, int a);
    if (NT[g] != 0) return (a % 2 == 0) ? 3'd5 : 3'd0;
    return 3'((a * 5 + k * 3 + a / 7) % 8);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int AW = $clog2(NW[g] * NH[g]);
    logic [AW-1:0] a;
    logic [14:0] dly [4];
    rom_blitter #(
      .IMG_W(NW[g]), .IMG_H(NH[g]), .COLOUR_W(3), .N_SCREENS(3), .SEL_W(2), .XY_W(10),
      .ROM_LAT(NL[g]), .TRANSP_EN(NT[g]), .TRANSP_KEY(0)
    ) u_dut (
      .clk(clk), .resetn(rstn[g]), .go(go[g]), .frame(frame[g]), .screen_select(sel[g]),
      .x0(x0[g]), .y0(y0[g]), .rom_addr(a), .rom_q_bus(bus[g]), .plot(plot[g]),
      .x(xo[g]), .y(yo[g]), .colour(col[g]), .busy(busy[g]), .done(done[g])
    );
    assign addr[g] = 15'(a);
    // synchronous ROM with NL[g] cycles of read latency
    always @(posedge clk) begin
      dly[0] <= addr[g];
      for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
    end
    assign bus[g] = {romv(g, 2, int'(dly[NL[g]-1])), romv(g, 1, int'(dly[NL[g]-1])),
                     romv(g, 0, int'(dly[NL[g]-1]))};
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic bit mbusy(int i, int c);
    return acc[i] >= 0 && c >= acc[i] + 1 && c <= acc[i] + NW[i] * NH[i] + NL[i] + 1;
  endfunction

  task automatic check_dut(int i);
    int n, np;
    bit win, eplot, edone, ebusy;
    np = NW[i] * NH[i];
    n = cyc - acc[i] - 1 - (NL[i] + 1);
    win = acc[i] >= 0 && n >= 0 && n < np;
    if (rst_pend[i]) begin
      ex[i] = '0; ey[i] = '0; ec[i] = '0; ea[i] = 0;
      eplot = 0; edone = 0; ebusy = 0;
      rst_pend[i] = 0;
    end else begin
      if (acc[i] >= 0 && cyc >= acc[i] + 1 && cyc <= acc[i] + np) ea[i] = cyc - acc[i] - 1;
      if (win) begin
        ec[i] = msel[i] < 3 ? romv(i, msel[i], n) : 3'd0;
        ex[i] = 10'(mx0[i] + n % NW[i]);
        ey[i] = 10'(my0[i] + n / NW[i]);
      end
      eplot = win && (NT[i] == 0 || ec[i] != 0);
      edone = win && n == np - 1;
      ebusy = mbusy(i, cyc);
    end
    chk($sformatf("d%0d cyc%0d {plot,busy,done,x,y,colour,addr}", i, cyc),
        64'({plot[i], busy[i], done[i], xo[i], yo[i], col[i], addr[i]}),
        64'({eplot, ebusy, edone, ex[i], ey[i], ec[i], 15'(ea[i])}));
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      if (!rstn[i]) begin
        rst_pend[i] = 1;
        acc[i] = -1;
      end else if (!mbusy(i, cyc) && go[i] && frame[i]) begin
        acc[i] = cyc;
        msel[i] = int'(sel[i]);
        mx0[i] = int'(x0[i]);
        my0[i] = int'(y0[i]);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) check_dut(i);
    if (bad >= 200) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  initial begin
    draw_t tbl [5];
    int d, a0, np, fo, fx, fy, doff, lx, ly, lp;
    tbl[0] = '{0, vga_pkg::SCR_TITLE, 0, 0, 19200, 3, 0, 0, 19202, 159, 119, 1};
    tbl[1] = '{0, vga_pkg::SCR_LOSE, 1020, 5, 19200, 3, 1020, 5, 19202, 155, 124, 1};
    tbl[2] = '{1, vga_pkg::SCR_WIN, 0, 0, 8, 5, 0, 0, 12, 3, 1, 1};
    tbl[3] = '{1, 3, 7, 1000, 8, 5, 7, 1000, 12, 10, 1001, 1};
    tbl[4] = '{2, vga_pkg::SCR_TITLE, 0, 0, 4, 4, 0, 0, 11, 3, 1, 0};
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 0; go[i] = 0; frame[i] = 0; sel[i] = '0; x0[i] = '0; y0[i] = '0;
      acc[i] = -1; rst_pend[i] = 0; ex[i] = '0; ey[i] = '0; ec[i] = '0; ea[i] = 0;
      msel[i] = 0; mx0[i] = 0; my0[i] = 0;
    end
    repeat (2) tick();
    for (int i = 0; i < 3; i++) rstn[i] = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset plot d%0d", i), 64'(plot[i]), 0);
      chk($sformatf("reset busy d%0d", i), 64'(busy[i]), 0);
      chk($sformatf("reset addr d%0d", i), 64'(addr[i]), 0);
    end
    // table of whole draws with per-draw summary expectations
    foreach (tbl[t]) begin
      d = tbl[t].d;
      sel[d] = 2'(tbl[t].sel); x0[d] = 10'(tbl[t].x0); y0[d] = 10'(tbl[t].y0);
      go[d] = 1; frame[d] = 1;
      a0 = cyc;
      tick();
      np = 0; fo = -1; fx = -1; fy = -1; doff = -1; lx = -1; ly = -1; lp = -1;
      for (int k = 0; k < NW[d] * NH[d] + NL[d] + 4 && busy[d]; k++) begin
        if (plot[d]) begin
          np++;
          if (fo < 0) begin fo = cyc - a0; fx = int'(xo[d]); fy = int'(yo[d]); end
        end
        if (done[d]) begin doff = cyc - a0; lx = int'(xo[d]); ly = int'(yo[d]); lp = int'(plot[d]); end
        go[d] = 1'($urandom); frame[d] = 1'($urandom); sel[d] = 2'($urandom);
        x0[d] = 10'($urandom); y0[d] = 10'($urandom);
        tick();
      end
      go[d] = 0; frame[d] = 0;
      chk($sformatf("t%0d idle after draw", t), 64'(busy[d]), 0);
      chk($sformatf("t%0d plots", t), 64'(np), 64'(tbl[t].plots));
      chk($sformatf("t%0d first plot offset", t), 64'(fo), 64'(tbl[t].first_off));
      chk($sformatf("t%0d first xy", t), 64'({fx, fy}), 64'({tbl[t].fx, tbl[t].fy}));
      chk($sformatf("t%0d done offset", t), 64'(doff), 64'(tbl[t].done_off));
      chk($sformatf("t%0d last xy", t), 64'({lx, ly}), 64'({tbl[t].lx, tbl[t].ly}));
      chk($sformatf("t%0d plot at done", t), 64'(lp), 64'(tbl[t].lplot));
    end
    // go held high, frame gates the start; restart the cycle after done
    go[1] = 1; frame[1] = 0;
    repeat (5) tick();
    chk("go without frame busy", 64'(busy[1]), 0);
    frame[1] = 1;
    tick();
    frame[1] = 0;
    chk("frame start busy", 64'(busy[1]), 1);
    chk("frame start addr", 64'(addr[1]), 0);
    for (int k = 0; k < 30 && !done[1]; k++) begin
      frame[1] = 1'($urandom);
      tick();
    end
    frame[1] = 0;
    chk("done seen with frames during busy", 64'(done[1]), 1);
    tick();
    chk("idle after done", 64'(busy[1]), 0);
    frame[1] = 1;
    tick();
    frame[1] = 0; go[1] = 0;
    chk("back-to-back busy", 64'(busy[1]), 1);
    chk("back-to-back addr", 64'(addr[1]), 0);
    for (int k = 0; k < 30 && busy[1]; k++) tick();
    chk("back-to-back finishes", 64'(busy[1]), 0);
    // reset while pixel 100 is on the outputs
    sel[0] = 2'(vga_pkg::SCR_WIN); x0[0] = '0; y0[0] = '0; go[0] = 1; frame[0] = 1;
    a0 = cyc;
    tick();
    go[0] = 0; frame[0] = 0;
    while (cyc < a0 + 103) tick();
    chk("pixel 100 x", 64'(xo[0]), 100);
    chk("pixel 100 plot", 64'(plot[0]), 1);
    rstn[0] = 0;
    tick();
    rstn[0] = 1;
    chk("abort plot", 64'(plot[0]), 0);
    chk("abort busy", 64'(busy[0]), 0);
    chk("abort done", 64'(done[0]), 0);
    go[0] = 1; frame[0] = 1;
    a0 = cyc;
    tick();
    go[0] = 0; frame[0] = 0;
    chk("restart addr", 64'(addr[0]), 0);
    chk("restart busy", 64'(busy[0]), 1);
    tick();
    tick();
    chk("restart first plot", 64'({plot[0], xo[0], yo[0]}), 64'({1'b1, 10'd0, 10'd0}));
    rstn[0] = 0;
    tick();
    rstn[0] = 1;
    // random traffic, mid-draw input churn and occasional resets on the small images
    for (int k = 0; k < 600; k++) begin
      for (int i = 1; i < 3; i++) begin
        go[i] = 1'($urandom); frame[i] = $urandom_range(0, 3) == 0; sel[i] = 2'($urandom);
        x0[i] = 10'($urandom); y0[i] = 10'($urandom); rstn[i] = $urandom_range(0, 99) != 0;
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin rstn[i] = 1; go[i] = 0; frame[i] = 0; end
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
